// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_state_e;

  localparam int DEFAULT_CLOCK_FREQUENCY = 50_000_000;
  localparam int DEFAULT_BAUD_RATE       = 115_200;

  function automatic int calc_clks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clock_frequency, input int baud_rate);
    return calc_clks_per_bit(clock_frequency, baud_rate) / 2;
  endfunction

  // Enough bits to hold CLKS_PER_BIT-1 so the timer never wraps within a bit.
  function automatic int calc_timer_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; all stages reset to RESET_VALUE.
module bit_synchronizer #(
  parameter int   DEPTH       = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic async_i,
  output logic sync_o
);

  logic [DEPTH-1:0] sync_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (!resetn) sync_q[gi] <= RESET_VALUE;
          else         sync_q[gi] <= async_i;
        end
      end else begin : g_rest
        always_ff @(posedge clock) begin
          if (!resetn) sync_q[gi] <= RESET_VALUE;
          else         sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling, single-entry valid/ready output,
// overrun and frame-error pulses, and break detection.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int TIMER_W      = calc_timer_width(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);

  logic line;

  bit_synchronizer #(
    .DEPTH      (2),
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clock  (clock),
    .resetn (resetn),
    .async_i(uart_rx),
    .sync_o (line)
  );

  uart_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_error_q, frame_error_d;
  logic               overrun_q, overrun_d;
  logic               good_byte;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_error_d = 1'b0;
    good_byte     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (!line) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = line ? ST_IDLE : ST_DATA;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (line) begin
            good_byte = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = ST_BREAK_WAIT;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_BREAK_WAIT: begin
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A handshake in the completion cycle frees the slot for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (good_byte) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_receiver;

  localparam int CLKS = 434;

  logic       clock = 1'b0;
  logic       resetn;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int n_checks   = 0;
  int n_failures = 0;
  int fe_cnt     = 0;
  int ov_cnt     = 0;
  int vrise_cnt  = 0;
  logic valid_prev = 1'b0;

  always #10 clock = ~clock;

  uart_receiver #(
    .CLOCK_FREQUENCY(50_000_000),
    .BAUD_RATE      (115_200)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Pulse and rising-edge counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid && !valid_prev) vrise_cnt++;
    valid_prev = rx_valid;
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge. When ready_edge >= 0, rx_ready is
  // high for exactly that posedge, counted from the first edge after the start bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int ready_edge);
    logic [9:0] bits;
    int edge_n;
    bits   = {stop_bit, data, 1'b0};
    edge_n = 0;
    for (int b = 0; b < 10; b++) begin
      uart_rx = bits[b];
      for (int c = 0; c < CLKS; c++) begin
        if (ready_edge >= 0) rx_ready = ((edge_n + 1) == ready_edge);
        @(posedge clock);
        edge_n++;
        @(negedge clock);
      end
    end
    if (ready_edge >= 0) rx_ready = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  int fe0, ov0, vr0;

  initial begin
    resetn   = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    @(negedge clock);
    tick(5);
    check_value("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check_value("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_value("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check_value("reset_overrun", {31'd0, overrun}, 32'd0);
    check_value("reset_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    tick(20);

    // Single good byte, then one-cycle handshake.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, -1);
    check_value("b55_valid", {31'd0, rx_valid}, 32'd1);
    check_value("b55_data", {24'd0, rx_data}, 32'h55);
    check_value("b55_busy_idle", {31'd0, busy}, 32'd0);
    check_value("b55_no_fe", fe_cnt - fe0, 32'd0);
    consume();
    check_value("b55_consumed", {31'd0, rx_valid}, 32'd0);

    // Back-to-back with no consumer: second byte dropped with one overrun.
    ov0 = ov_cnt;
    send_frame(8'hA3, 1'b1, -1);
    check_value("a3_data", {24'd0, rx_data}, 32'hA3);
    check_value("a3_no_overrun", ov_cnt - ov0, 32'd0);
    send_frame(8'h0F, 1'b1, -1);
    check_value("0f_kept_a3", {24'd0, rx_data}, 32'hA3);
    check_value("0f_valid", {31'd0, rx_valid}, 32'd1);
    check_value("0f_one_overrun", ov_cnt - ov0, 32'd1);
    consume();
    check_value("a3_consumed", {31'd0, rx_valid}, 32'd0);

    // Handshake in the exact completion cycle: new byte replaces old, no overrun.
    send_frame(8'h5A, 1'b1, -1);
    check_value("5a_data", {24'd0, rx_data}, 32'h5A);
    ov0 = ov_cnt;
    vr0 = vrise_cnt;
    send_frame(8'hC3, 1'b1, 4126);
    check_value("c3_replaced", {24'd0, rx_data}, 32'hC3);
    check_value("c3_valid", {31'd0, rx_valid}, 32'd1);
    check_value("c3_no_overrun", ov_cnt - ov0, 32'd0);
    check_value("c3_valid_never_dropped", vrise_cnt - vr0, 32'd0);
    consume();

    // Bad stop bit, then held-low break, then recovery.
    fe0 = fe_cnt;
    vr0 = vrise_cnt;
    send_frame(8'h3C, 1'b0, -1);
    check_value("3c_one_fe", fe_cnt - fe0, 32'd1);
    check_value("3c_no_valid", {31'd0, rx_valid}, 32'd0);
    check_value("3c_busy_break", {31'd0, busy}, 32'd1);
    tick(10000);
    check_value("break_still_one_fe", fe_cnt - fe0, 32'd1);
    check_value("break_busy", {31'd0, busy}, 32'd1);
    check_value("break_no_valid", vrise_cnt - vr0, 32'd0);
    uart_rx = 1'b1;
    tick(20);
    check_value("break_exit_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1, -1);
    check_value("81_data", {24'd0, rx_data}, 32'h81);
    check_value("81_valid", {31'd0, rx_valid}, 32'd1);

    // 100-cycle glitch on an idle line.
    fe0 = fe_cnt;
    vr0 = vrise_cnt;
    uart_rx = 1'b0;
    tick(50);
    check_value("glitch_busy", {31'd0, busy}, 32'd1);
    tick(50);
    uart_rx = 1'b1;
    tick(500);
    check_value("glitch_idle", {31'd0, busy}, 32'd0);
    check_value("glitch_no_fe", fe_cnt - fe0, 32'd0);
    check_value("glitch_no_valid", vrise_cnt - vr0, 32'd0);
    check_value("glitch_data_kept", {24'd0, rx_data}, 32'h81);

    // Reset during data bit 4 of 0xFF, then a clean 0x12.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    uart_rx = 1'b0;
    tick(CLKS);
    uart_rx = 1'b1;
    tick(4 * CLKS + 200);
    resetn = 1'b0;
    tick(2);
    check_value("midrst_data", {24'd0, rx_data}, 32'h00);
    check_value("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check_value("midrst_busy", {31'd0, busy}, 32'd0);
    check_value("midrst_fe", {31'd0, frame_error}, 32'd0);
    check_value("midrst_ov", {31'd0, overrun}, 32'd0);
    tick(1);
    resetn = 1'b1;
    tick(CLKS - 200 + 4 * CLKS);
    check_value("midrst_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    check_value("midrst_no_valid", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h12, 1'b1, -1);
    check_value("12_data", {24'd0, rx_data}, 32'h12);
    check_value("12_valid", {31'd0, rx_valid}, 32'd1);

    // Line held low across reset release.
    resetn  = 1'b0;
    uart_rx = 1'b0;
    tick(3);
    fe0 = fe_cnt;
    vr0 = vrise_cnt;
    resetn = 1'b1;
    tick(10000);
    check_value("lowrst_one_fe", fe_cnt - fe0, 32'd1);
    check_value("lowrst_busy", {31'd0, busy}, 32'd1);
    check_value("lowrst_no_valid", {31'd0, rx_valid}, 32'd0);
    check_value("lowrst_no_rise", vrise_cnt - vr0, 32'd0);
    uart_rx = 1'b1;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning synchronous, active-low reset.
REQ-005 SHALL have port uart_rx, input, 1, meaning asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, 8, meaning last received byte.
REQ-007 SHALL have port rx_valid, output, 1, meaning rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, 1, meaning the consumer accepts rx_data.
REQ-009 SHALL have port frame_error, output, 1, meaning one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1, meaning one-cycle pulse when a byte is dropped because rx_valid is still high.
REQ-011 SHALL have port busy, output, 1, meaning high in every state except IDLE.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronizer output.
REQ-013 SHALL use CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer division; 434 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (217).
REQ-014 SHALL implement states IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-015 IDLE SHALL go to START on the first cycle line=0, clearing the bit-timer.
REQ-016 START SHALL sample line after HALF_BIT cycles: if 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no output.
REQ-017 DATA SHALL sample line every CLKS_PER_BIT cycles, shift LSB-first into an 8-bit shift register, and go to STOP after the 8th sample.
REQ-018 STOP SHALL sample line after CLKS_PER_BIT cycles; if 1, the byte is good and the state returns to IDLE.
REQ-019 On a good byte with rx_valid=0, rx_data SHALL load the shift register and rx_valid SHALL rise on the clock edge following the stop sample.
REQ-020 On a good byte with rx_valid=1 and no handshake that cycle, the new byte SHALL be discarded, rx_data SHALL be kept, and overrun SHALL pulse for 1 cycle.
REQ-021 If rx_valid and rx_ready are both high in the cycle a good byte completes, the old byte SHALL be consumed, the new byte loaded, rx_valid SHALL stay 1, and there SHALL be no overrun.
REQ-022 rx_valid SHALL fall the cycle after rx_valid and rx_ready are both high, and SHALL otherwise hold.
REQ-023 rx_data SHALL remain stable while rx_valid=1.
REQ-024 If the STOP sample is 0, frame_error SHALL pulse for 1 cycle, no byte SHALL be delivered, and the state SHALL go to BREAK_WAIT.
REQ-025 BREAK_WAIT SHALL stay there while line=0 and go to IDLE on the first cycle line=1, so a held-low line yields exactly one frame_error.
REQ-026 The bit-timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap inside a bit.

Reset
REQ-027 While resetn=0 at a clock edge: state=IDLE, rx_data=0, rx_valid=0, frame_error=0, overrun=0, busy=0, synchronizer flops=1, shift register and timer=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no pulse outputs.
REQ-029 After reset releases, a frame whose start edge preceded the release SHALL not be decoded; the next falling edge seen in IDLE starts a frame.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state enum typedef and the CLKS_PER_BIT/HALF_BIT calculation, for reuse by a later transmitter.
REQ-031 The synchronizer SHALL be one sub-module, bit_synchronizer (parameterised depth, reset value), instantiated once.

Verification (50 MHz, 115200 baud, 8680 ns per bit)
REQ-032 Send 0x55 with a good stop bit and rx_ready=0 -> rx_valid=1 and rx_data=0x55 after the stop sample; rx_ready=1 for one cycle -> rx_valid=0 the next cycle.
REQ-033 Send 0xA3 then 0x0F back-to-back with rx_ready held 0 -> rx_data=0xA3 retained, one overrun pulse during the second stop bit.
REQ-034 Send 0x3C with stop bit=0 -> one frame_error pulse, rx_valid stays 0; line then held low 10000 cycles -> no further pulses; line high then send 0x81 -> rx_data=0x81.
REQ-035 Low glitch of 100 cycles on an idle line -> return to IDLE, no rx_valid and no frame_error.
REQ-036 resetn=0 for 3 cycles during data bit 4 of 0xFF -> all outputs 0; next full 0x12 frame -> rx_data=0x12.
REQ-037 uart_rx held 0 from reset release for 10000 cycles -> exactly one frame_error, busy stays 1 (BREAK_WAIT), rx_valid stays 0.
